// File: rtl/convert_fixed_to_float.sv
// Multi-cycle converter from signed Q5.26 fixed point to IEEE-754 single precision.
// The magnitude is normalised one bit per cycle, then packed with a truncated mantissa.
module convert_fixed_to_float (
    input  logic        CLK,
    input  logic        RST_FF,
    input  logic        RST_FSM_FF,
    input  logic        Begin_FSM_FF,
    input  logic [31:0] FIXED,
    output logic [31:0] FLOAT,
    output logic        ACK_FF,
    output logic        BUSY_FF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        sign;
    logic        sign_next;
    logic [31:0] mag;
    logic [31:0] mag_next;
    logic [4:0]  cnt;
    logic [4:0]  cnt_next;
    logic [31:0] float_next;
    logic [7:0]  exp_val;

    // The MSB of the normalised magnitude sits at weight 2^(31-26-cnt), so the biased
    // exponent is 127 + 5 - cnt; cnt is at most 31, which keeps it within 101..132.
    assign exp_val = 8'd132 - {3'b000, cnt};

    always_comb begin
        // NOTE: every signal driven here gets its hold value first, so no branch can infer a latch.
        state_next = state;
        sign_next  = sign;
        mag_next   = mag;
        cnt_next   = cnt;
        float_next = FLOAT;

        unique case (state)
            IDLE: begin
                if (Begin_FSM_FF) begin
                    sign_next  = FIXED[31];
                    // Negating 0x80000000 wraps back to itself, which is the correct unsigned magnitude.
                    mag_next   = FIXED[31] ? (~FIXED + 32'd1) : FIXED;
                    cnt_next   = 5'd0;
                    state_next = NORM;
                end
            end
            NORM: begin
                if (mag == 32'd0) begin
                    float_next = 32'h0000_0000;
                    state_next = DONE;
                end else if (mag[31]) begin
                    state_next = PACK;
                end else begin
                    mag_next = {mag[30:0], 1'b0};
                    cnt_next = cnt + 5'd1;
                end
            end
            PACK: begin
                float_next = {sign, exp_val, mag[30:8]};
                state_next = DONE;
            end
            DONE: begin
                if (RST_FSM_FF) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            FLOAT <= 32'h0000_0000;
            sign  <= 1'b0;
            mag   <= 32'd0;
            cnt   <= 5'd0;
        end else begin
            FLOAT <= float_next;
            sign  <= sign_next;
            mag   <= mag_next;
            cnt   <= cnt_next;
        end
    end

    // Status flags depend on the state register alone, never on an input.
    assign ACK_FF  = (state == DONE);
    assign BUSY_FF = (state != IDLE);

endmodule

// File: tb/tb_convert_fixed_to_float.sv
// Scoreboard bench for convert_fixed_to_float: the stimulus pushes expected results and
// ACK cycles computed arithmetically, and a monitor checks every ACK rising edge.
module tb_convert_fixed_to_float;

    logic        CLK          = 1'b0;
    logic        RST_FF       = 1'b1;
    logic        RST_FSM_FF   = 1'b0;
    logic        Begin_FSM_FF = 1'b0;
    logic [31:0] FIXED        = 32'd0;
    logic [31:0] FLOAT;
    logic        ACK_FF;
    logic        BUSY_FF;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] f;
        int          at;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_float = 32'd0;
    logic        ack_prev   = 1'b0;

    convert_fixed_to_float dut (
        .CLK          (CLK),
        .RST_FF       (RST_FF),
        .RST_FSM_FF   (RST_FSM_FF),
        .Begin_FSM_FF (Begin_FSM_FF),
        .FIXED        (FIXED),
        .FLOAT        (FLOAT),
        .ACK_FF       (ACK_FF),
        .BUSY_FF      (BUSY_FF)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Value = FIXED / 2^26; the float is found from the position of the leading one of |value|.
    function automatic void model(input logic [31:0] x, output logic [31:0] f, output int lat);
        longint v;
        longint m;
        longint frac;
        longint man;
        int     p;
        int     e;
        v = longint'($signed(x));
        m = (v < 0) ? -v : v;
        if (m == 0) begin
            f   = 32'h0000_0000;
            lat = 1;
            return;
        end
        p = 0;
        while ((longint'(1) << (p + 1)) <= m) p++;
        e    = p - 26 + 127;
        frac = m - (longint'(1) << p);
        man  = (p >= 23) ? (frac >> (p - 23)) : (frac << (23 - p));
        f    = {(v < 0), e[7:0], man[22:0]};
        lat  = 2 + (31 - p);
    endfunction

    // Monitor: every rising ACK must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (ACK_FF && !ack_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {31'd0, ACK_FF}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("float_value", FLOAT, e.f);
                check("ack_cycle", cyc, e.at);
            end
        end
        ack_prev = ACK_FF;
    end

    task automatic convert(input logic [31:0] x, input bit poke, input bit both_release);
        logic [31:0] ef;
        int          lat;
        int          n;
        int          t;
        model(x, ef, lat);
        @(negedge CLK);
        check("float_hold_idle", FLOAT, last_float);
        RST_FF       = 1'b0;
        FIXED        = x;
        Begin_FSM_FF = 1'b1;
        t            = cyc + 1;
        sb.push_back('{ef, t + lat});
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        FIXED        = $urandom;
        check("busy_after_begin", {31'd0, BUSY_FF}, 32'd1);
        if (poke) begin
            Begin_FSM_FF = 1'b1;
            FIXED        = $urandom;
            @(negedge CLK);
            Begin_FSM_FF = 1'b0;
        end
        n = 0;
        while (!ACK_FF && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!ACK_FF) check("ack_timeout", {31'd0, ACK_FF}, 32'd1);
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        check("done_hold", {FLOAT[31:0]}, ef);
        check("ack_hold", {31'd0, ACK_FF}, 32'd1);
        RST_FSM_FF   = 1'b1;
        Begin_FSM_FF = both_release;
        @(negedge CLK);
        RST_FSM_FF   = 1'b0;
        Begin_FSM_FF = 1'b0;
        check("release_flags", {30'd0, BUSY_FF, ACK_FF}, 32'd0);
        check("float_after_release", FLOAT, ef);
        @(negedge CLK);
        check("idle_stays_idle", {31'd0, BUSY_FF}, 32'd0);
        last_float = ef;
    endtask

    task automatic abort_case();
        @(negedge CLK);
        FIXED        = 32'h0400_0000;
        Begin_FSM_FF = 1'b1;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_FF = 1'b1;
        @(negedge CLK);
        RST_FF = 1'b0;
        check("abort_float", FLOAT, 32'h0000_0000);
        check("abort_flags", {30'd0, BUSY_FF, ACK_FF}, 32'd0);
        repeat (40) @(negedge CLK);
        check("abort_still_idle", {30'd0, BUSY_FF, ACK_FF}, 32'd0);
        last_float = 32'h0000_0000;
    endtask

    // Directed expectations written straight from the IEEE-754 encodings.
    task automatic directed(input logic [31:0] x, input logic [31:0] f_exp, input int lat_exp);
        logic [31:0] f;
        int          lat;
        model(x, f, lat);
        check("model_float", f, f_exp);
        check("model_latency", lat, lat_exp);
        convert(x, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_float", FLOAT, 32'h0000_0000);
        check("reset_flags", {30'd0, BUSY_FF, ACK_FF}, 32'd0);

        directed(32'h0400_0000, 32'h3F80_0000, 7);
        directed(32'hFA00_0000, 32'hBFC0_0000, 7);
        directed(32'h0000_0000, 32'h0000_0000, 1);
        directed(32'h8000_0000, 32'hC200_0000, 2);
        directed(32'h0000_0001, 32'h3280_0000, 33);

        convert(32'h0400_0000, 1'b1, 1'b0);
        abort_case();
        convert(32'hFA00_0000, 1'b0, 1'b1);
        convert(32'h7FFF_FFFF, 1'b1, 1'b0);
        convert(32'hFFFF_FFFF, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] x;
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = ~x + 32'd1;
            convert(x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge CLK);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/convert_fixed_to_float.md
CONVERT_FIXED_TO_FLOAT -- requirements
Module: convert_fixed_to_float

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The port list SHALL be:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_FF  input  1  system reset; synchronous, active-high.
- RST_FSM_FF  input  1  handshake release; returns the block from DONE to IDLE.
- Begin_FSM_FF  input  1  start request; sampled only in IDLE.
- FIXED  input  32  signed two's-complement fixed-point operand, 26 fraction bits (value = FIXED / 2^26).
- FLOAT  output  32  IEEE-754 single-precision result, registered.
- ACK_FF  output  1  result valid; high only in DONE.
- BUSY_FF  output  1  high in every state except IDLE.

Function
REQ-003 The block SHALL implement the states IDLE, NORM, PACK and DONE, held in a registered state variable.
REQ-004 In IDLE, when Begin_FSM_FF=1, the block SHALL perform the following on that edge, then go to NORM:
- SIGN <= FIXED[31].
- MAG <= |FIXED|, a 32-bit unsigned value; 0x80000000 yields MAG=0x80000000.
- CNT <= 0.
REQ-005 In IDLE, when Begin_FSM_FF=0, the block SHALL stay in IDLE and all registers SHALL hold.
REQ-006 NORM SHALL be evaluated with priority as follows:
- MAG=0: FLOAT <= 0x00000000 and go to DONE.
- else if MAG[31]=1: go to PACK.
- else: MAG <= MAG<<1, CNT <= CNT+1, and stay in NORM.
REQ-007 CNT SHALL be 5 bits wide and SHALL never exceed 31 for a nonzero operand.
REQ-008 In PACK, the block SHALL load FLOAT <= {SIGN, EXP, MAG[30:8]} with EXP = 8'd132 - CNT, then go to DONE.
REQ-009 The mantissa SHALL be truncated (round toward zero); no rounding logic is required.
REQ-010 EXP SHALL always lie in 101..132; no denormal, infinity or NaN SHALL ever be produced.
REQ-011 A zero operand SHALL produce +0 (0x00000000), regardless of sign.
REQ-012 In DONE, ACK_FF SHALL be 1. The block SHALL stay in DONE until RST_FSM_FF=1, then go to IDLE on that edge.
REQ-013 Latency from the edge that samples Begin_FSM_FF (edge t) SHALL be:
- nonzero operand: ACK_FF first high after edge t+2+CNT_final.
- zero operand: ACK_FF first high after edge t+1.
REQ-014 Begin_FSM_FF SHALL be ignored in NORM, PACK and DONE.
REQ-015 RST_FSM_FF SHALL be ignored outside DONE.
REQ-016 Begin_FSM_FF and RST_FSM_FF high together in DONE SHALL only return the block to IDLE; no new conversion starts on that edge.
REQ-017 FLOAT SHALL remain stable from its load until the next load in NORM or PACK; it SHALL stay valid after the return to IDLE.
REQ-018 FIXED SHALL be sampled only on the Begin edge; later changes to FIXED SHALL NOT affect the result in flight.
REQ-019 ACK_FF and BUSY_FF SHALL be decoded from the registered state only, with no combinational path from any input.

Reset
REQ-020 On a rising edge with RST_FF=1, the block SHALL load:
- state <= IDLE.
- FLOAT <= 0x00000000.
- SIGN <= 0, MAG <= 0, CNT <= 0.
- ACK_FF = 0, BUSY_FF = 0.
REQ-021 RST_FF SHALL take priority over every other input in any state, including mid-NORM; the aborted conversion SHALL produce no ACK_FF.
REQ-022 After reset, the first Begin_FSM_FF SHALL be accepted on the first edge after RST_FF deasserts.

Verification
REQ-023 Directed scenarios:
- FIXED=0x04000000 (1.0), Begin at edge t -> FLOAT=0x3F800000, ACK_FF high after edge t+7 (CNT=5).
- FIXED=0xFA000000 (-1.5) -> FLOAT=0xBFC00000, ACK_FF after t+7.
- FIXED=0x00000000 -> FLOAT=0x00000000, ACK_FF after t+1.
- FIXED=0x80000000 (-32.0) -> FLOAT=0xC2000000, ACK_FF after t+2 (CNT=0).
- FIXED=0x00000001 (2^-26) -> FLOAT=0x32800000, ACK_FF after t+33 (CNT=31).
- Begin pulsed while in NORM is ignored.
- RST_FF asserted at t+3 of the 1.0 case -> IDLE, FLOAT=0, ACK_FF never rises.
- A new Begin after RST_FSM_FF converts correctly.
